// File: rtl/calc_arbiter_seq.sv
// Two-requester round-robin front end for a shared add/sub/mul/div unit with a multi-cycle restoring divider.
// Optional: define CALC_OP_COUNT_EN to add a saturating response-handshake counter on op_count.
module calc_arbiter_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [5:0]     req_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_result,
  output logic           rsp_err
`ifdef CALC_OP_COUNT_EN
  ,
  output logic [15:0]    op_count
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DIV, RESP} state_t;
  localparam int CW = $clog2(W + 1);

  state_t        state;
  logic [W-1:0]  a_q, b_q, quo_q, rem_q;
  logic [2:0]    op_q;
  logic          id_q, last_grant;
  logic [CW-1:0] cnt_q;

  logic          grant_id;
  logic [W-1:0]  g_a, g_b;
  logic [2:0]    g_op;
  logic [W:0]    shifted, diff;
  logic          take;

  // Both valid: the one not served last wins; otherwise the single valid one.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid == 2'b11)  grant_id = ~last_grant;
    else if (req_valid[1])   grant_id = 1'b1;
    g_a  = grant_id ? req_a[2*W-1:W] : req_a[W-1:0];
    g_b  = grant_id ? req_b[2*W-1:W] : req_b[W-1:0];
    g_op = grant_id ? req_op[5:3]    : req_op[2:0];
    req_ready = 2'b00;
    if (state == IDLE && req_valid[grant_id]) req_ready = grant_id ? 2'b10 : 2'b01;
  end

  // Restoring step: shift next dividend bit into the partial remainder.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, b_q};
    take    = (shifted >= {1'b0, b_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      quo_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          a_q        <= g_a;
          b_q        <= g_b;
          op_q       <= g_op;
          id_q       <= grant_id;
          last_grant <= grant_id;
          quo_q      <= g_a;
          rem_q      <= '0;
          cnt_q      <= '0;
          state      <= (g_op == 3'd3 && g_b != '0) ? DIV : EXEC;
        end
        EXEC: begin
          rsp_err <= 1'b0;
          case (op_q)
            3'd0:    rsp_result <= {{(W-1){1'b0}}, {1'b0, a_q} + {1'b0, b_q}};
            3'd1:    rsp_result <= {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
            3'd2:    rsp_result <= {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
            3'd3: begin
              rsp_result <= '1;
              rsp_err    <= 1'b1;
            end
            default: begin
              rsp_result <= '0;
              rsp_err    <= 1'b1;
            end
          endcase
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        DIV: begin
          // W shift-subtract steps, then one cycle to publish the quotient.
          if (cnt_q == CW'(W)) begin
            rsp_result <= {{W{1'b0}}, quo_q};
            rsp_err    <= 1'b0;
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            rem_q <= take ? diff[W-1:0] : shifted[W-1:0];
            quo_q <= {quo_q[W-2:0], take};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CALC_OP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                   op_count <= '0;
    else if (state == RESP && rsp_ready && op_count != 16'hFFFF)  op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_calc_arbiter_seq.sv
// Randomized self-checking bench for calc_arbiter_seq against an arithmetic reference model.
module tb_calc_arbiter_seq;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic [5:0]  req_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_result;
`ifdef CALC_OP_COUNT_EN
  logic [15:0] op_count;
`endif

  calc_arbiter_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err)
`ifdef CALC_OP_COUNT_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int lg = 1;   // model: requester served last
  int hs = 0;   // model: handshakes since reset

  function automatic logic [16:0] model(input int a, input int b, input int op);
    case (op)
      0:       return {1'b0, 16'(a + b)};
      1:       return {1'b0, 16'(a - b)};
      2:       return {1'b0, 16'(a * b)};
      3:       return (b == 0) ? {1'b1, 16'hFFFF} : {1'b0, 16'(a / b)};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  function automatic int model_grant(input logic [1:0] vm, input int last);
    if (vm == 2'b11) return 1 - last;
    return vm[1] ? 1 : 0;
  endfunction

  function automatic int model_lat(input int op, input int b);
    return (op == 3 && b != 0) ? W + 2 : 2;
  endfunction

  // Drives one request, waits for accept and response, completes the handshake.
  task automatic run_one(input logic [1:0] vm, input logic [15:0] ab, input logic [15:0] bb,
                         input logic [5:0] ob, input bit keep, output int gnt, output int lat,
                         output logic [15:0] res, output logic id, output logic er, output bit tmo);
    int n;
    tmo = 0; gnt = -1; lat = 0; n = 0; res = '0; id = 0; er = 0;
    req_valid = vm; req_a = ab; req_b = bb; req_op = ob; rsp_ready = 0;
    while (gnt < 0 && n < 20) begin
      #1;
      if (req_ready[0] && req_valid[0]) gnt = 0;
      else if (req_ready[1] && req_valid[1]) gnt = 1;
      @(posedge clk); #1; n++;
    end
    if (gnt < 0) begin tmo = 1; req_valid = 0; return; end
    if (!keep) begin
      req_valid = 0; req_a = 16'($urandom); req_b = 16'($urandom); req_op = 6'($urandom);
    end
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin tmo = 1; return; end
    res = rsp_result; id = rsp_id; er = rsp_err;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0; req_valid = 0; req_a = 0; req_b = 0; req_op = 0; rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    lg = 1; hs = 0;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    tests++; if (rsp_result !== 16'h0) begin fails++; $display("FAIL reset_rsp_result got %0h want 0", rsp_result); end
    tests++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin fails++; $display("FAIL reset_id_err got %0b/%0b want 0/0", rsp_id, rsp_err); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %0b want 00", req_ready); end
`ifdef CALC_OP_COUNT_EN
    tests++; if (op_count !== 16'd0) begin fails++; $display("FAIL reset_op_count got %0d want 0", op_count); end
`endif
  endtask

  task automatic test_directed();
    int ga[5], gb[5], gop[5], gr[5];
    logic [1:0] vm[5];
    int gnt, lat;
    logic [15:0] res; logic id, er; bit tmo;
    logic [16:0] e;
    logic [15:0] ab, bb; logic [5:0] ob;
    ga  = '{200, 3, 250, 9, 4};
    gb  = '{100, 5, 7, 0, 6};
    gop = '{0, 1, 3, 3, 5};
    gr  = '{0, 1, 1, 0, 1};
    vm  = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 5; i++) begin
      ab = 16'($urandom); bb = 16'($urandom); ob = 6'($urandom);
      if (gr[i] == 1) begin ab[15:8] = 8'(ga[i]); bb[15:8] = 8'(gb[i]); ob[5:3] = 3'(gop[i]); end
      else            begin ab[7:0]  = 8'(ga[i]); bb[7:0]  = 8'(gb[i]); ob[2:0] = 3'(gop[i]); end
      run_one(vm[i], ab, bb, ob, 0, gnt, lat, res, id, er, tmo);
      e = model(ga[i], gb[i], gop[i]);
      tests++;
      if (tmo) begin fails++; $display("FAIL dir%0d_timeout got timeout want response", i); continue; end
      lg = gr[i]; hs++;
      if (res !== e[15:0]) begin fails++; $display("FAIL dir%0d_result got %0h want %0h", i, res, e[15:0]); end
      tests++; if (er !== e[16]) begin fails++; $display("FAIL dir%0d_err got %0b want %0b", i, er, e[16]); end
      tests++; if (id !== 1'(gr[i])) begin fails++; $display("FAIL dir%0d_id got %0b want %0d", i, id, gr[i]); end
      tests++; if (lat != model_lat(gop[i], gb[i])) begin fails++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, model_lat(gop[i], gb[i])); end
    end
  endtask

  task automatic test_fairness();
    int gnt, lat, eg;
    logic [15:0] res; logic id, er; bit tmo;
    for (int i = 0; i < 4; i++) begin
      eg = model_grant(2'b11, lg);
      run_one(2'b11, {8'd15, 8'd15}, {8'd17, 8'd17}, {3'd2, 3'd2}, 1, gnt, lat, res, id, er, tmo);
      tests++;
      if (tmo) begin fails++; $display("FAIL fair%0d_timeout got timeout want response", i); continue; end
      lg = eg; hs++;
      if (gnt != eg) begin fails++; $display("FAIL fair%0d_grant got %0d want %0d", i, gnt, eg); end
      tests++; if (res !== 16'd255 || er !== 1'b0) begin fails++; $display("FAIL fair%0d_result got %0h/%0b want ff/0", i, res, er); end
      tests++; if (id !== 1'(eg)) begin fails++; $display("FAIL fair%0d_id got %0b want %0d", i, id, eg); end
    end
    req_valid = 0;
  endtask

  task automatic test_random();
    int a[2], b[2], o[2];
    logic [1:0] vm;
    int gnt, lat, eg, nerr;
    logic [15:0] res; logic id, er; bit tmo;
    logic [16:0] e;
    nerr = 0;
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++) begin
        a[r] = $urandom_range(0, 255);
        b[r] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 255);
        o[r] = ($urandom_range(0, 2) == 0) ? 3 : $urandom_range(0, 7);
      end
      vm = 2'($urandom_range(1, 3));
      eg = model_grant(vm, lg);
      run_one(vm, {8'(a[1]), 8'(a[0])}, {8'(b[1]), 8'(b[0])}, {3'(o[1]), 3'(o[0])}, 0,
              gnt, lat, res, id, er, tmo);
      e = model(a[eg], b[eg], o[eg]);
      tests++;
      if (tmo) begin fails++; $display("FAIL rnd%0d_timeout got timeout want response", i); continue; end
      lg = eg; hs++;
      if (gnt != eg || id !== 1'(eg)) begin fails++; $display("FAIL rnd%0d_grant got %0d/%0b want %0d", i, gnt, id, eg); end
      tests++; if (res !== e[15:0] || er !== e[16]) begin
        fails++; $display("FAIL rnd%0d_result op %0d a %0d b %0d got %0h/%0b want %0h/%0b", i, o[eg], a[eg], b[eg], res, er, e[15:0], e[16]);
      end
      tests++; if (lat != model_lat(o[eg], b[eg])) begin fails++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, model_lat(o[eg], b[eg])); end
    end
`ifdef CALC_OP_COUNT_EN
    tests++; if (op_count !== 16'(hs)) begin fails++; $display("FAIL rnd_op_count got %0d want %0d", op_count, hs); end
`endif
  endtask

  task automatic test_backpressure();
    int n;
    logic [15:0] r0; logic i0, e0;
    n = 0;
    req_valid = 2'b01; req_a = 16'd200; req_b = 16'd100; req_op = 6'd0; rsp_ready = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    tests++;
    if (!rsp_valid) begin fails++; $display("FAIL bp_timeout got no response want response"); req_valid = 0; return; end
    lg = 0;
    r0 = rsp_result; i0 = rsp_id; e0 = rsp_err;
    req_valid = 2'b11;
    if (r0 !== 16'd300) begin fails++; $display("FAIL bp_result got %0h want 12c", r0); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      tests++;
      if (!rsp_valid || rsp_result !== r0 || rsp_id !== i0 || rsp_err !== e0) begin
        fails++; $display("FAIL bp_hold%0d got v%0b %0h id%0b want v1 %0h id%0b", c, rsp_valid, rsp_result, rsp_id, r0, i0);
      end
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_ready%0d got %0b want 00", c, req_ready); end
    end
    rsp_ready = 1; #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_hs_ready got %0b want 00", req_ready); end
    @(posedge clk); #1;
    hs++;
    rsp_ready = 0;
    tests++;
    if (req_ready !== (model_grant(2'b11, lg) == 1 ? 2'b10 : 2'b01)) begin
      fails++; $display("FAIL bp_next_ready got %0b want grant %0d", req_ready, model_grant(2'b11, lg));
    end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_post_valid got %0b want 0", rsp_valid); end
    req_valid = 0;
  endtask

  task automatic test_reset_mid();
    int n, gnt, lat;
    logic [15:0] res; logic id, er; bit tmo;
    n = 0;
    req_valid = 2'b10; req_a = {8'd250, 8'd0}; req_b = {8'd7, 8'd0}; req_op = {3'd3, 3'd0};
    #1;
    while (!(req_ready[1]) && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    tests++;
    if (rsp_valid !== 0 || rsp_result !== 16'h0 || rsp_id !== 0 || rsp_err !== 0) begin
      fails++; $display("FAIL rstmid_outputs got v%0b %0h id%0b e%0b want all 0", rsp_valid, rsp_result, rsp_id, rsp_err);
    end
`ifdef CALC_OP_COUNT_EN
    tests++; if (op_count !== 16'd0) begin fails++; $display("FAIL rstmid_op_count got %0d want 0", op_count); end
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    lg = 1; hs = 0;
    repeat (12) begin
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_ghost got rsp_valid 1 want 0"); end
    end
    run_one(2'b11, {8'd20, 8'd10}, {8'd4, 8'd5}, {3'd0, 3'd2}, 0, gnt, lat, res, id, er, tmo);
    tests++;
    if (tmo) begin fails++; $display("FAIL rstmid_timeout got timeout want response"); return; end
    hs++; lg = 0;
    if (gnt != 0 || id !== 1'b0) begin fails++; $display("FAIL rstmid_grant got %0d want 0", gnt); end
    tests++; if (res !== 16'd50) begin fails++; $display("FAIL rstmid_result got %0h want 32", res); end
`ifdef CALC_OP_COUNT_EN
    tests++; if (op_count !== 16'd1) begin fails++; $display("FAIL rstmid_op_count1 got %0d want 1", op_count); end
`endif
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_directed();
    test_fairness();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/calc_arbiter_seq.md
Name: calc_arbiter_seq

Overview:
- Shares one calculator datapath (add/sub/mul/div on W-bit operands, 2W-bit result) between two requesters.
- Round-robin arbitration, valid/ready request and response handshakes.
- Multi-cycle restoring divider sequenced by an FSM.
- Sits between client blocks and the result bus; one operation in flight at a time.

Parameters:
- W, 8, operand width; result width is 2*W; divide takes W iteration cycles.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept; at most one bit high
- req_a  in  2*W  operand a; bits [W*i +: W] belong to requester i
- req_b  in  2*W  operand b, same packing
- req_op  in  6  opcode, bits [3*i +: 3]: 0 add, 1 sub, 2 mul, 3 div, 4-7 illegal
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  1  requester index of the response
- rsp_result  out  2*W  operation result
- rsp_err  out  1  divide-by-zero or illegal opcode

Behaviour:
- Reset (async assert, sync release): state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, last_grant=1 (requester 0 wins first), internal operand/divider registers=0. Reset mid-operation abandons the operation; no response is produced.
- States: IDLE, EXEC, DIV, RESP.
- IDLE, grant selection:
  - One valid requester: grant it.
  - Both valid: grant ~last_grant.
  - None valid: no grant.
  - req_ready[g] = (state==IDLE) && req_valid[g], combinational. req_ready is 0 in all other states.
- Accept (req_valid[g] && req_ready[g] at an edge): latch a, b, op and id=g; last_grant<=g.
  - Go to DIV if op==3 and b!=0; otherwise go to EXEC.
- EXEC (one cycle), registered result:
  - add: zero-extended a+b (W+1 significant bits).
  - sub: 2W-bit two's complement of a-b. Example: a=3, b=5 -> 16'hFFFE.
  - mul: full 2W-bit a*b.
  - div with b==0: result all-ones, err=1.
  - op 4-7: result 0, err=1.
  - Next state: RESP.
- DIV: restoring shift-subtract, one quotient bit per cycle, MSB first, W cycles. Result = zero-extended quotient; remainder discarded; err=0. Next state: RESP.
- RESP: rsp_valid=1; rsp_id, rsp_result and rsp_err stay stable until rsp_valid && rsp_ready at an edge, then return to IDLE. No new request is accepted in the handshake cycle.
- Latency from accept edge to first rsp_valid=1 cycle: 2 cycles via EXEC, W+2 cycles via DIV.
- Requester inputs are sampled only at accept; later changes to them have no effect.
- Throughput: at most one accept per (latency + 1) cycles.
- Fairness: with both requesters continuously valid, grants strictly alternate.

Optional Feature:
- CALC_OP_COUNT_EN
- Defined: adds output port op_count [15:0], reset 0. Increments on each response handshake and saturates at 16'hFFFF.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Req0 add a=200, b=100 -> rsp_valid 2 cycles after accept; result=16'd300, id=0, err=0.
- Req1 sub a=3, b=5 -> result=16'hFFFE, err=0; then req1 div a=250, b=7 -> result=16'd35 after W+2=10 cycles.
- Div a=9, b=0 -> result=16'hFFFF, err=1 after 2 cycles; op=5 -> result=0, err=1.
- Both requesters valid continuously with mul 15*17 -> grants alternate 0,1,0,1; every result=16'd255, rsp_id alternates.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp outputs stable, req_ready=0 throughout; after handshake, next accept is possible the cycle after.
- Assert rst_n=0 during cycle 4 of a divide -> outputs return to reset values immediately; after release, req0 wins a simultaneous request; with CALC_OP_COUNT_EN, op_count=0 after reset and 1 after the next handshake.
